// File: rtl/adder_stage1_pkg.sv
// Shared op codes, skid-buffer state encoding and default operand width for adder_stage1.
// `LEN_DATA normally comes from main.def.v; a 32-bit fallback keeps standalone builds working.
`ifndef LEN_DATA
`define LEN_DATA 31
`endif

package adder_stage1_pkg;

    localparam logic [1:0] ADD_OP_ADD = 2'b00;
    localparam logic [1:0] ADD_OP_SUB = 2'b01;
    localparam logic [1:0] ADD_OP_ADC = 2'b10;
    localparam logic [1:0] ADD_OP_SBC = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_st_e;

    // op[0] selects inverted B; op[1] selects the external carry over the implicit SUB carry.
    function automatic logic op_carry0(input logic [1:0] op, input logic carry_in);
        return op[1] ? carry_in : op[0];
    endfunction

endpackage

// File: rtl/adder_stage1_gp_init_cell.sv
// One bit of operand-B conditioning plus raw generate/propagate terms.
module gp_init_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic inv_i,
    output logic g_o,
    output logic p_o
);
    logic b_cond;

    assign b_cond = b_i ^ inv_i;
    assign g_o    = a_i & b_cond;
    assign p_o    = a_i ^ b_cond;
endmodule

// File: rtl/adder_stage1.sv
// Prefix-adder front stage: g/p init with carry folded into bit 0, registered behind a 2-entry skid buffer.
// Optional stall counter output enabled by defining ADDER_STAGE1_STALL_CNT_EN.
module adder_stage1
    import adder_stage1_pkg::*;
#(
    parameter int W = `LEN_DATA + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] operand_a,
    input  logic [W-1:0] operand_b,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] generate_out,
    output logic [W-1:0] propogate_out,
    output logic [W-1:0] half_sum_out,
    output logic         carry0_out
`ifdef ADDER_STAGE1_STALL_CNT_EN
    ,
    output logic [31:0]  stall_count
`endif
);

    typedef struct packed {
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W-1:0] hs;
        logic         c0;
    } beat_t;

    logic [W-1:0] g_raw;
    logic [W-1:0] p_raw;
    logic         c0;
    beat_t        beat_new;

    skid_st_e state_q, state_d;
    beat_t    or_q, or_d;
    beat_t    sk_q, sk_d;
    logic     in_ready_q;
    logic     accept;

    for (genvar i = 0; i < W; i++) begin : g_cell
        gp_init_cell u_cell (
            .a_i   (operand_a[i]),
            .b_i   (operand_b[i]),
            .inv_i (op[0]),
            .g_o   (g_raw[i]),
            .p_o   (p_raw[i])
        );
    end

    // Bit 0 absorbs the carry-in, so downstream prefix stages see a resolved bit 0.
    assign c0 = op_carry0(op, carry_in);
    always_comb begin
        beat_new      = '0;
        beat_new.g    = {g_raw[W-1:1], g_raw[0] | (p_raw[0] & c0)};
        beat_new.p    = {p_raw[W-1:1], 1'b0};
        beat_new.hs   = p_raw;
        beat_new.c0   = c0;
    end

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    or_d    = beat_new;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && out_ready) begin
                    or_d = beat_new;
                end else if (accept) begin
                    sk_d    = beat_new;
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    or_d    = sk_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            or_q       <= '0;
            sk_q       <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            or_q       <= or_d;
            sk_q       <= sk_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != ST_EMPTY);
    assign generate_out  = or_q.g;
    assign propogate_out = or_q.p;
    assign half_sum_out  = or_q.hs;
    assign carry0_out    = or_q.c0;

`ifdef ADDER_STAGE1_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: doc/adder_stage1.md
Name: adder_stage1

Overview:
- Front stage of the prefix adder pipeline, directly upstream of adder_stage2.
- Accepts operands and an op code through a valid/ready handshake.
- Conditions operand B for subtraction and computes per-bit generate/propagate with the carry-in folded into bit 0.
- Registers the result so the combinational prefix stages start from a flop boundary.
- Includes a 2-entry skid buffer so `in_ready` is purely registered.

Parameters:
- W, `LEN_DATA+1, operand width in bits; all data buses are [W-1:0] (i.e. [`LEN_DATA:0]).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage can accept a beat; registered.
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- operand_a  in  W  operand A.
- operand_b  in  W  operand B.
- carry_in  in  1  external carry; used only by ADC/SBC.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- generate_out  out  W  per-bit generate, carry folded into bit 0; feeds adder_stage2 generate_in.
- propogate_out  out  W  per-bit propagate; bit 0 forced 0; feeds adder_stage2 propogate_in.
- half_sum_out  out  W  A xor B' (unmodified), for the final sum stage.
- carry0_out  out  1  effective carry into bit 0, for the final sum stage.

Behaviour:
- Operand conditioning:
  - B' = op[0] ? ~operand_b : operand_b.
  - c0 = op[1] ? carry_in : op[0]. SUB therefore uses c0 = 1.
- Bitwise terms:
  - g[i] = A[i] & B'[i], p[i] = A[i] ^ B'[i].
  - g[0] |= p[0] & c0.
  - propogate_out[0] = 0, because the carry into bit 0 is resolved.
  - half_sum_out = p, with bit 0 unmodified.
  - All arithmetic is modulo 2^W; there is no overflow handling here.
- Storage:
  - Output register OR: the beat presented downstream.
  - Skid register SK.
  - Each holds {g, p, hs, c0}.
- States:
  - EMPTY: OR invalid. An accepted beat goes to OR → ONE.
  - ONE:
    - accept & out_ready: OR reloads with the new beat, stay ONE.
    - accept & !out_ready: beat goes to SK → FULL.
    - !accept & out_ready → EMPTY.
    - !accept & !out_ready: hold.
  - FULL:
    - in_ready = 0.
    - out_ready: OR <= SK → ONE.
    - Otherwise hold.
- Handshake:
  - Accept = in_valid & in_ready.
  - in_ready = (state != FULL), registered.
  - out_valid = (state != EMPTY).
  - OR contents are stable while out_valid & !out_ready.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY or draining. Throughput is 1 beat/cycle with out_ready held high.
- Simultaneous events: in FULL, in_valid is ignored because in_ready = 0. In ONE with accept and out_ready both high, the old beat leaves and the new beat lands in OR in the same edge.
- Reset:
  - state = EMPTY, in_ready = 1, out_valid = 0.
  - All data outputs 0.
  - A reset asserted mid-operation drops both OR and SK beats.
- Inputs are sampled only on accept; op/operands are don't-care otherwise.

Optional Feature:
- Macro ADDER_STAGE1_STALL_CNT_EN.
- Enabled:
  - Adds output `stall_count`, 32 bits.
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at all-ones.
  - Cleared by rst.
- Disabled: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- main.def.v: `LEN_DATA (existing).
- Package/define additions:
  - op encodings ADD_OP_ADD/SUB/ADC/SBC, 2 bits.
  - skid state encodings ST_EMPTY/ST_ONE/ST_FULL.
- One natural sub-module: gp_init_cell, one bit of B conditioning plus g/p. Instantiate it W times in a generate loop, with bit 0 handling c0 folding at top level.

Test Plan (W=32):
- ADD: A=0x0000_00FF, B=0x0000_0001, out_ready=1 → next cycle:
  - out_valid=1, carry0_out=0
  - generate_out=0x0000_0001, propogate_out=0x0000_00FE, half_sum_out=0x0000_00FE
- SUB: A=5, B=3 → B'=0xFFFF_FFFC, carry0_out=1:
  - generate_out=0x0000_0005, propogate_out=0xFFFF_FFF8, half_sum_out=0xFFFF_FFF9
- ADC with carry_in=1: A=0xFFFF_FFFF, B=0 → generate_out=0x0000_0001, propogate_out=0xFFFF_FFFE, carry0_out=1.
- Backpressure:
  - out_ready=0 with 3 consecutive beats offered → first in OR, second in SK, in_ready=0 after 2 accepts, third held.
  - Release out_ready → beats exit in order 1, 2, 3 with no loss or duplication.
- rst pulsed while FULL → next cycle out_valid=0, in_ready=1, outputs 0. A subsequent beat emerges after 1 cycle.
- With ADDER_STAGE1_STALL_CNT_EN: out_ready=0 for 10 cycles with a beat valid → stall_count=10.
